// File: rtl/mips_alu_pkg.sv
// Shared MIPS ALU definitions: control codes used by the EX ALU and its decoder,
// plus the state encoding of the shift-add multiply sequencer.
package mips_alu_pkg;

  localparam logic [3:0] CTL_AND  = 4'b0000;
  localparam logic [3:0] CTL_OR   = 4'b0001;
  localparam logic [3:0] CTL_ADDU = 4'b0010;
  localparam logic [3:0] CTL_SRL  = 4'b0011;
  localparam logic [3:0] CTL_SUBU = 4'b0110;
  localparam logic [3:0] CTL_SLT  = 4'b0111;
  localparam logic [3:0] CTL_XOR  = 4'b1001;
  localparam logic [3:0] CTL_SLL  = 4'b1010;
  localparam logic [3:0] CTL_SRA  = 4'b1011;
  localparam logic [3:0] CTL_NOR  = 4'b1100;
  localparam logic [3:0] CTL_SLTU = 4'b1110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/mips_alu.sv
// Combinational EX-stage ALU. Shifts take the amount from the low bits of a and
// shift operand b, matching how the decoder routes shamt/rs onto operand a.
module mips_alu
  import mips_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       ctrl,
  output logic [WIDTH-1:0] y,
  output logic             zero
);

  localparam int SH_W = $clog2(WIDTH);

  logic [SH_W-1:0] shamt;

  assign shamt = a[SH_W-1:0];

  always_comb begin
    y = '0;
    case (ctrl)
      CTL_AND:  y = a & b;
      CTL_OR:   y = a | b;
      CTL_ADDU: y = a + b;
      CTL_SUBU: y = a - b;
      CTL_SLT:  y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      CTL_SLTU: y = {{(WIDTH-1){1'b0}}, (a < b)};
      CTL_XOR:  y = a ^ b;
      CTL_NOR:  y = ~(a | b);
      CTL_SLL:  y = b << shamt;
      CTL_SRL:  y = b >> shamt;
      CTL_SRA:  y = $signed(b) >>> shamt;
      default:  y = '0;
    endcase
  end

  assign zero = (y == '0);

endmodule

// File: rtl/mult_alu_sequencer.sv
// MULTU controller: borrows the shared EX ALU for one shift-add step per cycle
// and delivers a full 2*WIDTH-bit unsigned product into registered hi/lo.
module mult_alu_sequencer
  import mips_alu_pkg::*;
#(
  parameter int         WIDTH    = 32,
  parameter logic [3:0] ALU_ADDU = CTL_ADDU
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             alu_own,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_out
);

  localparam int               CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  // Handshake: start is accepted only in IDLE with flush low. busy is high for
  // the WIDTH RUN cycles plus the DONE cycle; done pulses for one cycle in DONE,
  // and hi/lo carry the new product from the following cycle until the next
  // completion. A flush in RUN/DONE returns to IDLE with hi/lo untouched.
  seq_state_t       state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mplr;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] sum;
  logic             carry;

  // alu_own is registered and high exactly while in RUN, so it gates the operands.
  assign alu_in1 = alu_own ? acc   : '0;
  assign alu_in2 = alu_own ? mcand : '0;

  // An unsigned add overflowed iff the wrapped result is smaller than an addend.
  always_comb begin
    sum   = acc;
    carry = 1'b0;
    if (mplr[0]) begin
      sum   = alu_out;
      carry = (alu_out < acc);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mcand    <= '0;
      acc      <= '0;
      mplr     <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      alu_own  <= 1'b0;
      alu_ctrl <= 4'b0000;
    end else begin
      alu_ctrl <= ALU_ADDU;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !flush) begin
            mcand   <= op_a;
            mplr    <= op_b;
            acc     <= '0;
            cnt     <= '0;
            state   <= RUN;
            busy    <= 1'b1;
            alu_own <= 1'b1;
          end
        end
        RUN: begin
          if (flush) begin
            state   <= IDLE;
            busy    <= 1'b0;
            alu_own <= 1'b0;
          end else begin
            acc  <= {carry, sum[WIDTH-1:1]};
            mplr <= {sum[0], mplr[WIDTH-1:1]};
            cnt  <= cnt + 1'b1;
            if (cnt == LAST) begin
              state   <= DONE;
              alu_own <= 1'b0;
              done    <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (!flush) begin
            hi <= acc;
            lo <= mplr;
          end
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          alu_own <= 1'b0;
        end
      endcase
    end
  end

  a_own_implies_busy : assert property (@(posedge clk) disable iff (rst) alu_own |-> busy);
  a_done_implies_busy : assert property (@(posedge clk) disable iff (rst) done |-> busy);

endmodule

// File: tb/tb_mult_alu_sequencer.sv
// Bench for mult_alu_sequencer wired to the real EX ALU: table-driven products,
// random products, and hand-written flush / restart / reset sequences.
module tb_mult_alu_sequencer;
  import mips_alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         flush;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         alu_own;
  logic [W-1:0] alu_in1;
  logic [W-1:0] alu_in2;
  logic [3:0]   alu_ctrl;
  logic [W-1:0] alu_out;
  logic         alu_zero;

  mult_alu_sequencer #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .flush    (flush),
    .op_a     (op_a),
    .op_b     (op_b),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .alu_own  (alu_own),
    .alu_in1  (alu_in1),
    .alu_in2  (alu_in2),
    .alu_ctrl (alu_ctrl),
    .alu_out  (alu_out)
  );

  mips_alu #(.WIDTH(W)) u_alu (
    .a    (alu_in1),
    .b    (alu_in2),
    .ctrl (alu_ctrl),
    .y    (alu_out),
    .zero (alu_zero)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached expected finish");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int           checks = 0;
  int           errors = 0;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] exp_v;
  bit           result_pending = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // hi/lo are compared on the cycle after each done pulse.
  always @(negedge clk) begin
    if (result_pending) begin
      result_pending = 1'b0;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got 0x%0h expected no completion", {hi, lo});
      end else begin
        exp_v = exp_q.pop_front();
        check("product", {hi, lo}, exp_v);
      end
    end
    if (done && !rst) result_pending = 1'b1;
  end

  // ---------------- driver tasks ----------------
  // Returns #1 after the accepting edge, i.e. inside the first RUN cycle.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit push, input logic [63:0] exp);
    @(posedge clk);
    #1;
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    if (push) exp_q.push_back(exp);
    @(posedge clk);
    #1;
    start = 1'b0;
    op_a  = $urandom_range(32'hFFFF_FFFF, 0);
    op_b  = $urandom_range(32'hFFFF_FFFF, 0);
  endtask

  task automatic wait_done(input string tag);
    int busy_n = 0;
    int own_n  = 0;
    int done_at = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (alu_own) own_n++;
      if (done) done_at = k;
      if (!busy) break;
    end
    check({tag, "_busy_cycles"}, 64'(busy_n), 64'd33);
    check({tag, "_own_cycles"}, 64'(own_n), 64'd32);
    check({tag, "_done_cycle"}, 64'(done_at), 64'd33);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  vec_t vecs[7];

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [63:0]  last_exp;
    int           n;

    vecs[0] = '{32'd3,          32'd5,          32'h0000_0000, 32'h0000_000F};
    vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{32'h8000_0000,  32'd2,          32'h0000_0001, 32'h0000_0000};
    vecs[3] = '{32'd0,          32'h1234_5678,  32'h0000_0000, 32'h0000_0000};
    vecs[4] = '{32'hFFFF_FFFF,  32'd2,          32'h0000_0001, 32'hFFFF_FFFE};
    vecs[5] = '{32'h0001_0000,  32'h0001_0000,  32'h0000_0001, 32'h0000_0000};
    vecs[6] = '{32'd7,          32'd9,          32'h0000_0000, 32'h0000_003F};

    rst   = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    op_a  = '0;
    op_b  = '0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_alu_own", alu_own, 0);
    check("rst_alu_in1", alu_in1, 0);
    check("rst_alu_in2", alu_in2, 0);
    check("rst_alu_ctrl", alu_ctrl, 0);
    check("rst_alu_zero", alu_zero, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("idle_alu_ctrl", alu_ctrl, 64'(CTL_ADDU));
    check("idle_busy", busy, 0);

    // table-driven products
    for (int i = 0; i < 7; i++) begin
      start_op(vecs[i].a, vecs[i].b, 1'b1, {vecs[i].hi, vecs[i].lo});
      wait_done($sformatf("vec%0d", i));
    end

    // random products against a 64-bit model
    for (int i = 0; i < 4; i++) begin
      ra = $urandom_range(32'hFFFF_FFFF, 0);
      rb = $urandom_range(32'hFFFF_FFFF, 0);
      start_op(ra, rb, 1'b1, {32'b0, ra} * {32'b0, rb});
      wait_done("rand");
    end

    // flush at RUN cycle 10: no done, hi/lo keep 0x0/0xF
    start_op(32'd3, 32'd5, 1'b1, 64'h0000_0000_0000_000F);
    wait_done("pre_flush");
    start_op(32'd7, 32'd9, 1'b0, 64'd0);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_busy", busy, 0);
    check("flush_alu_own", alu_own, 0);
    check("flush_done", done, 0);
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) n++;
    end
    check("flush_no_activity", 64'(n), 64'd0);
    check("flush_hi", hi, 0);
    check("flush_lo", lo, 64'hF);
    start_op(32'd7, 32'd9, 1'b1, 64'h3F);
    wait_done("post_flush");

    // start re-asserted during RUN is ignored
    last_exp = {32'b0, 32'h0000_1234} * {32'b0, 32'h0000_5678};
    start_op(32'h0000_1234, 32'h0000_5678, 1'b1, last_exp);
    fork
      wait_done("restart");
      begin
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1;
        op_a  = 32'hFFFF_FFFF;
        op_b  = 32'h0000_0003;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
    join

    // start together with flush in IDLE: nothing starts
    @(posedge clk);
    #1;
    start = 1'b1;
    flush = 1'b1;
    op_a  = 32'd5;
    op_b  = 32'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    n = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy || alu_own) n++;
    end
    check("start_flush_idle", 64'(n), 64'd0);
    check("start_flush_hilo", {hi, lo}, last_exp);

    // reset at RUN cycle 20
    start_op(32'd11, 32'd13, 1'b0, 64'd0);
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_hi", hi, 0);
    check("midrst_lo", lo, 0);
    check("midrst_alu_own", alu_own, 0);
    check("midrst_alu_in1", alu_in1, 0);
    check("midrst_alu_in2", alu_in2, 0);
    check("midrst_alu_ctrl", alu_ctrl, 0);
    start_op(32'd2, 32'd2, 1'b1, 64'd4);
    wait_done("post_reset");

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
